// File: rtl/hls_monitor_pkg.sv
// Shared types and helpers for the HLS deadlock monitor.
// Holds the monitor FSM encoding and the index helpers sized by the top.
package hls_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNTING = 2'd1,
        BLOCKED  = 2'd2
    } state_e;

    // Widest cause vector the lowest-set-bit helper can scan.
    localparam int LSB_MAX_W = 256;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int lowest_set_idx(input logic [LSB_MAX_W-1:0] v);
        int idx;
        idx = 0;
        for (int i = LSB_MAX_W - 1; i >= 0; i--) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/hls_stall_detect.sv
// Combinational stall reduction over AXIS block and sub-instance idle/block indicators.
// Zero latency, no state; the instance term needs all instances parked and one blocked.
module hls_stall_detect #(
    parameter int N_AXIS = 2,
    parameter int N_INST = 1
) (
    input  logic [N_AXIS-1:0] axis_block_sigs,
    input  logic [N_INST-1:0] inst_idle_sigs,
    input  logic [N_INST-1:0] inst_block_sigs,
    output logic              stall_now
);

    logic axis_any;
    logic inst_all_parked;
    logic inst_any_blocked;

    assign axis_any         = |axis_block_sigs;
    assign inst_all_parked  = &(inst_idle_sigs | inst_block_sigs);
    assign inst_any_blocked = |inst_block_sigs;

    assign stall_now = axis_any | (inst_all_parked & inst_any_blocked);

endmodule

// File: rtl/hls_deadlock_monitor_param.sv
// Deadlock monitor: flags block after THRESH consecutive stalled samples, records onset cause.
// block/pending are registered state decodes; clear releases and wins over any same-edge transition.
module hls_deadlock_monitor_param
    import hls_monitor_pkg::*;
#(
    parameter int N_AXIS = 2,
    parameter int N_INST = 1,
    parameter int THRESH = 16,
    parameter bit STICKY = 1'b1,
    parameter int EVT_W  = 16,
    localparam int IDX_W = clog2_min1(N_AXIS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_AXIS-1:0] axis_block_sigs,
    input  logic [N_INST-1:0] inst_idle_sigs,
    input  logic [N_INST-1:0] inst_block_sigs,
    input  logic              clear,
    output logic              block,
    output logic              pending,
    output logic [N_AXIS-1:0] cause_axis,
    output logic [N_INST-1:0] cause_inst,
    output logic [IDX_W-1:0]  first_axis_idx,
    output logic [EVT_W-1:0]  event_count
);

    localparam int CNT_W = $clog2(THRESH + 1);

    logic              stall_now;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_AXIS-1:0] cause_axis_q, cause_axis_d;
    logic [N_INST-1:0] cause_inst_q, cause_inst_d;
    logic [EVT_W-1:0]  evt_q, evt_d;
    logic              onset;
    logic              enter_blocked;

    hls_stall_detect #(
        .N_AXIS (N_AXIS),
        .N_INST (N_INST)
    ) u_stall_detect (
        .axis_block_sigs (axis_block_sigs),
        .inst_idle_sigs  (inst_idle_sigs),
        .inst_block_sigs (inst_block_sigs),
        .stall_now       (stall_now)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            IDLE: begin
                if (stall_now) begin
                    if (THRESH == 1) begin
                        state_d = BLOCKED;
                    end else begin
                        state_d = COUNTING;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            COUNTING: begin
                if (!stall_now) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(THRESH - 1)) begin
                    state_d = BLOCKED;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BLOCKED: begin
                if (!STICKY && !stall_now) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A same-edge clear suppresses the onset capture and the event increment too.
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_comb begin
        block          = (state_q == BLOCKED);
        pending        = (state_q == COUNTING);
        first_axis_idx = IDX_W'(lowest_set_idx(LSB_MAX_W'(cause_axis_q)));
    end

    assign onset         = (state_q == IDLE) && (state_d != IDLE);
    assign enter_blocked = (state_q != BLOCKED) && (state_d == BLOCKED);

    always_comb begin
        cause_axis_d = cause_axis_q;
        cause_inst_d = cause_inst_q;
        evt_d        = evt_q;
        if (onset) begin
            cause_axis_d = axis_block_sigs;
            cause_inst_d = inst_block_sigs;
        end
        if (enter_blocked && (evt_q != '1)) begin
            evt_d = evt_q + EVT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q        <= '0;
            cause_axis_q <= '0;
            cause_inst_q <= '0;
            evt_q        <= '0;
        end else begin
            cnt_q        <= cnt_d;
            cause_axis_q <= cause_axis_d;
            cause_inst_q <= cause_inst_d;
            evt_q        <= evt_d;
        end
    end

    assign cause_axis  = cause_axis_q;
    assign cause_inst  = cause_inst_q;
    assign event_count = evt_q;

endmodule

// File: tb/tb_hls_deadlock_monitor_param.sv
// Bench for hls_deadlock_monitor_param: three parameterisations share one stimulus stream,
// each tracked by a run-length reference model feeding a per-cycle scoreboard.
module tb_hls_deadlock_monitor_param;

    logic       clock = 1'b0;
    logic       reset;
    logic       clear;
    logic [2:0] axis;
    logic [2:0] idle;
    logic [2:0] blk;

    always #5 clock = ~clock;

    // DUT 0: THRESH=4 sticky, 2-bit saturating events
    logic       a_block, a_pending;
    logic [2:0] a_ca, a_ci;
    logic [1:0] a_idx;
    logic [1:0] a_ev;
    // DUT 1: THRESH=1 non-sticky
    logic       b_block, b_pending;
    logic [2:0] b_ca, b_ci;
    logic [1:0] b_idx;
    logic [3:0] b_ev;
    // DUT 2: default parameters
    logic        c_block, c_pending;
    logic [1:0]  c_ca;
    logic [0:0]  c_ci;
    logic [0:0]  c_idx;
    logic [15:0] c_ev;

    hls_deadlock_monitor_param #(
        .N_AXIS(3), .N_INST(3), .THRESH(4), .STICKY(1'b1), .EVT_W(2)
    ) dut_a (
        .clock(clock), .reset(reset),
        .axis_block_sigs(axis), .inst_idle_sigs(idle), .inst_block_sigs(blk),
        .clear(clear), .block(a_block), .pending(a_pending),
        .cause_axis(a_ca), .cause_inst(a_ci), .first_axis_idx(a_idx), .event_count(a_ev)
    );

    hls_deadlock_monitor_param #(
        .N_AXIS(3), .N_INST(3), .THRESH(1), .STICKY(1'b0), .EVT_W(4)
    ) dut_b (
        .clock(clock), .reset(reset),
        .axis_block_sigs(axis), .inst_idle_sigs(idle), .inst_block_sigs(blk),
        .clear(clear), .block(b_block), .pending(b_pending),
        .cause_axis(b_ca), .cause_inst(b_ci), .first_axis_idx(b_idx), .event_count(b_ev)
    );

    hls_deadlock_monitor_param dut_c (
        .clock(clock), .reset(reset),
        .axis_block_sigs(axis[1:0]), .inst_idle_sigs(idle[0:0]), .inst_block_sigs(blk[0:0]),
        .clear(clear), .block(c_block), .pending(c_pending),
        .cause_axis(c_ca), .cause_inst(c_ci), .first_axis_idx(c_idx), .event_count(c_ev)
    );

    typedef struct packed {
        logic        blk;
        logic        pend;
        logic [2:0]  ca;
        logic [2:0]  ci;
        logic [1:0]  idx;
        logic [15:0] ev;
    } obs_t;
    typedef obs_t [2:0] obs3_t;

    obs3_t sbq[$];

    int p_na[3] = '{3, 3, 2};
    int p_ni[3] = '{3, 3, 1};
    int p_th[3] = '{4, 1, 16};
    int p_st[3] = '{1, 0, 1};
    int p_ew[3] = '{2, 4, 16};

    bit         m_flag[3];
    int         m_run[3];
    int         m_ev[3];
    logic [2:0] m_ca[3];
    logic [2:0] m_ci[3];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic bit model_stall(input int d, input logic [2:0] ax,
                                       input logic [2:0] idl, input logic [2:0] bk);
        bit any_axis = 0;
        bit all_parked = 1;
        bit any_blocked = 0;
        for (int i = 0; i < p_na[d]; i++) if (ax[i]) any_axis = 1;
        for (int i = 0; i < p_ni[d]; i++) begin
            if (!(idl[i] || bk[i])) all_parked = 0;
            if (bk[i]) any_blocked = 1;
        end
        return any_axis || (all_parked && any_blocked);
    endfunction

    function automatic void model_step(input int d, input logic [2:0] ax, input logic [2:0] idl,
                                       input logic [2:0] bk, input logic clr, input logic rst);
        bit s;
        s = model_stall(d, ax, idl, bk);
        if (rst) begin
            m_flag[d] = 0; m_run[d] = 0; m_ev[d] = 0; m_ca[d] = 0; m_ci[d] = 0;
        end else if (clr) begin
            m_flag[d] = 0; m_run[d] = 0;
        end else if (m_flag[d]) begin
            if (p_st[d] == 0 && !s) m_flag[d] = 0;
        end else if (s) begin
            if (m_run[d] == 0) begin
                m_ca[d] = ax & 3'((1 << p_na[d]) - 1);
                m_ci[d] = bk & 3'((1 << p_ni[d]) - 1);
            end
            m_run[d]++;
            if (m_run[d] >= p_th[d]) begin
                m_flag[d] = 1;
                m_run[d]  = 0;
                if (m_ev[d] < (1 << p_ew[d]) - 1) m_ev[d]++;
            end
        end else begin
            m_run[d] = 0;
        end
    endfunction

    function automatic obs_t model_obs(input int d);
        obs_t o;
        o.blk  = m_flag[d];
        o.pend = !m_flag[d] && (m_run[d] > 0);
        o.ca   = m_ca[d];
        o.ci   = m_ci[d];
        o.idx  = 2'd0;
        for (int i = 2; i >= 0; i--) if (m_ca[d][i]) o.idx = 2'(i);
        o.ev   = 16'(m_ev[d]);
        return o;
    endfunction

    task automatic cyc(input logic [2:0] ax, input logic [2:0] idl, input logic [2:0] bk,
                       input logic clr, input logic rst);
        obs3_t e;
        axis = ax; idle = idl; blk = bk; clear = clr; reset = rst;
        @(posedge clock);
        for (int d = 0; d < 3; d++) begin
            model_step(d, ax, idl, bk, clr, rst);
            e[d] = model_obs(d);
        end
        sbq.push_back(e);
        #1;
    endtask

    task automatic hold(input int n, input logic [2:0] ax, input logic [2:0] idl, input logic [2:0] bk);
        repeat (n) cyc(ax, idl, bk, 1'b0, 1'b0);
    endtask

    function automatic void check(input string name, input int d, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d @%0t: got %0h expected %0h", name, d, $time, act, exp);
    endfunction

    obs3_t act_m, exp_m;
    initial begin
        forever begin
            @(negedge clock);
            if (sbq.size() > 0) begin
                exp_m = sbq.pop_front();
                act_m[0] = '{blk: a_block, pend: a_pending, ca: a_ca, ci: a_ci, idx: a_idx, ev: 16'(a_ev)};
                act_m[1] = '{blk: b_block, pend: b_pending, ca: b_ca, ci: b_ci, idx: b_idx, ev: 16'(b_ev)};
                act_m[2] = '{blk: c_block, pend: c_pending, ca: {1'b0, c_ca}, ci: {2'b00, c_ci},
                             idx: {1'b0, c_idx}, ev: c_ev};
                for (int d = 0; d < 3; d++) begin
                    check("block",          d, 32'(act_m[d].blk),  32'(exp_m[d].blk));
                    check("pending",        d, 32'(act_m[d].pend), 32'(exp_m[d].pend));
                    check("cause_axis",     d, 32'(act_m[d].ca),   32'(exp_m[d].ca));
                    check("cause_inst",     d, 32'(act_m[d].ci),   32'(exp_m[d].ci));
                    check("first_axis_idx", d, 32'(act_m[d].idx),  32'(exp_m[d].idx));
                    check("event_count",    d, 32'(act_m[d].ev),   32'(exp_m[d].ev));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] r_ax, r_idl, r_bk;
        r_ax = 0; r_idl = 3'b111; r_bk = 0;

        repeat (3) cyc(3'b000, 3'b111, 3'b000, 1'b0, 1'b1);

        // Long single-channel stall, then drop, then release
        hold(20, 3'b010, 3'b111, 3'b000);
        hold(3, 3'b000, 3'b111, 3'b000);
        cyc(3'b000, 3'b111, 3'b000, 1'b1, 1'b0);

        // Run-length restart: 3 stalled, 1 clear, 4 stalled
        hold(3, 3'b001, 3'b111, 3'b000);
        hold(1, 3'b000, 3'b111, 3'b000);
        hold(4, 3'b001, 3'b111, 3'b000);
        hold(2, 3'b000, 3'b111, 3'b000);
        cyc(3'b000, 3'b111, 3'b000, 1'b1, 1'b0);

        // Instance term: parked-and-blocked versus one active instance
        hold(6, 3'b000, 3'b011, 3'b100);
        hold(4, 3'b000, 3'b001, 3'b100);
        cyc(3'b000, 3'b111, 3'b000, 1'b1, 1'b0);

        // Sticky hold, clear with stall still high, re-flag, then reset mid-block
        hold(6, 3'b100, 3'b111, 3'b000);
        hold(3, 3'b000, 3'b111, 3'b000);
        cyc(3'b100, 3'b111, 3'b000, 1'b1, 1'b0);
        hold(6, 3'b100, 3'b111, 3'b000);
        cyc(3'b100, 3'b111, 3'b000, 1'b0, 1'b1);
        hold(3, 3'b000, 3'b111, 3'b000);

        // Repeated separate events to drive the narrow counter into saturation
        repeat (5) begin
            hold(5, 3'b011, 3'b111, 3'b000);
            cyc(3'b000, 3'b111, 3'b000, 1'b1, 1'b0);
            hold(2, 3'b000, 3'b111, 3'b000);
        end

        // Randomised patterns held for a few cycles each
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(7) == 0) begin
                r_ax  = ($urandom_range(1) == 1) ? 3'($urandom) : 3'b000;
                r_idl = 3'($urandom);
                r_bk  = ($urandom_range(2) == 0) ? 3'($urandom) : 3'b000;
            end
            cyc(r_ax, r_idl, r_bk, ($urandom_range(39) == 0), ($urandom_range(299) == 0));
        end

        @(negedge clock);
        #1;
        check("scoreboard_drain", 0, 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hls_deadlock_monitor_param.md
# hls_deadlock_monitor_param

Parametrised deadlock monitor for one HLS accelerator instance. It watches N AXI-Stream block indicators and M sub-instance idle/block indicators. A stall must persist for THRESH consecutive cycles before `block` is raised. It records which channels caused the stall and counts deadlock events. It sits beside the accelerator top, and its `block` output feeds the simulation deadlock reporter.

## Interface
Parameters:
- N_AXIS, 2, number of AXIS block indicators (>=1)
- N_INST, 1, number of sub-instance idle/block pairs (>=1)
- THRESH, 16, consecutive stall cycles required before flagging (>=1)
- STICKY, 1, 1: `block` holds until `clear`/reset; 0: `block` drops when the stall ends
- EVT_W, 16, width of the event counter

Ports:
- clock  in  1  clock; all logic on its rising edge
- reset  in  1  synchronous, active-high
- axis_block_sigs  in  N_AXIS  per-channel AXIS stall indicator
- inst_idle_sigs  in  N_INST  per-instance idle
- inst_block_sigs  in  N_INST  per-instance blocked
- clear  in  1  synchronous release of a sticky flag
- block  out  1  deadlock flagged
- pending  out  1  stall present, still below threshold
- cause_axis  out  N_AXIS  AXIS snapshot taken at stall onset
- cause_inst  out  N_INST  inst_block snapshot taken at stall onset
- first_axis_idx  out  clog2(N_AXIS) (min 1)  lowest set bit of cause_axis; 0 if none
- event_count  out  EVT_W  number of entries into BLOCKED, saturating

## Operation
- Stall term: stall_now = OR(axis_block_sigs) OR ( AND(inst_idle_sigs | inst_block_sigs) AND OR(inst_block_sigs) ).
  - The instance term means every instance is idle or blocked, and at least one is blocked.
- FSM states: IDLE, COUNTING, BLOCKED. Run-length counter `cnt` has width clog2(THRESH+1).
- IDLE:
  - stall_now=1 and THRESH=1 -> BLOCKED.
  - stall_now=1 and THRESH>1 -> COUNTING, cnt<=1.
  - On either exit, capture cause_axis<=axis_block_sigs and cause_inst<=inst_block_sigs.
- COUNTING:
  - stall_now=0 -> IDLE, cnt<=0.
  - stall_now=1 and cnt==THRESH-1 -> BLOCKED.
  - Otherwise cnt<=cnt+1.
- BLOCKED:
  - STICKY=1: remains until clear=1 -> IDLE.
  - STICKY=0: stall_now=0 -> IDLE; clear=1 -> IDLE.
- clear also applies in COUNTING and returns the FSM to IDLE. clear has priority over every transition, including one taken in the same cycle.
- event_count increments on each transition into BLOCKED and saturates at all-ones. It is not affected by clear.
- Cause registers update only on IDLE exit. They hold their value after release until the next onset.
- Output decode: block = (state==BLOCKED); pending = (state==COUNTING). Both are registered state decodes with no combinational path from the inputs.

## Timing
- Reset values:
  - state=IDLE, cnt=0
  - block=0, pending=0
  - cause_axis=0, cause_inst=0, first_axis_idx=0
  - event_count=0
- Latency: stall_now first sampled high at edge k -> block=1 after edge k+THRESH-1, provided stall_now stays high at every edge k..k+THRESH-1.
- With THRESH=1, block is high in the cycle after the first stalled sample.
- One stall-free sample during COUNTING restarts the run length from zero.
- Release, STICKY=0: stall_now low at edge j -> block=0 after edge j.
- Release via clear: clear high at edge j -> block=0 after edge j.
- Same-edge events:
  - clear=1 and stall_now=1 at one edge -> IDLE; detection restarts at the next edge.
  - reset overrides clear and stall.
- Reset mid-COUNTING or mid-BLOCKED discards all state.

## Structure
- Shared package `hls_monitor_pkg`:
  - state enum (IDLE, COUNTING, BLOCKED)
  - function clog2_min1
  - function lowest-set-bit index
- Sub-module `hls_stall_detect`: combinational stall_now reduction, parametrised by N_AXIS and N_INST. All sequential logic stays in the top module.

## Test plan
- Defaults, axis_block_sigs=2'b10 held 20 cycles:
  - pending=1 for 15 cycles, then block=1 from cycle 16 after onset.
  - cause_axis=2'b10, first_axis_idx=1, event_count=1.
- Run-length restart, THRESH=4: stall for 3 cycles, 1 cycle clear of stall, then stall for 4 cycles.
  - block rises only after the second run (7 cycles after the first onset).
  - event_count=1.
- Instance term, N_INST=3: idle=3'b011 with block=3'b100 -> stall_now=1.
  - Changing idle to 3'b001 -> no stall.
- STICKY=1: stall drops after flagging -> block stays 1.
  - Pulse clear with stall still high -> block=0 next cycle, re-flagged after THRESH cycles, event_count=2.
- STICKY=0, THRESH=1: stall high 5 cycles -> block high exactly 5 cycles, delayed by one cycle.
  - Reset asserted mid-block -> all outputs return to their reset values in the next cycle.
- Saturation, EVT_W=2: five separate deadlock events -> event_count stays at 3.
